decryption_controller: RTL and testbench



---
 rtl/decryption_controller.sv | 203 ++++++++++++++++++++
 tb/tb_decryption_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decryption_controller.sv
// rtl/decryption_controller.sv - AES-128 inverse-cipher sequencing controller
//
// Captures a ciphertext, requests key expansion, then steps an external
// combinational inverse datapath through the initial AddRoundKey, nine full
// inverse rounds and the final round. The plaintext is presented with a
// one-cycle done pulse.
//
// Optional feature macro: DECRYPT_ABORT_EN (adds i_abort).
//
// Ports:
//   i_clk                    rising-edge clock
//   i_rst                    synchronous active-high reset
//   i_abort                  (DECRYPT_ABORT_EN only) drop the current operation
//   i_decrypt_enable         start request, sampled in IDLE only
//   i_cipher_in[127:0]       ciphertext, captured together with the start
//   i_key_ready              round-key schedule complete
//   i_round_result[127:0]    datapath output for the current enables
//   o_key_schedule_start     one-cycle key expansion request
//   o_round_key_index[3:0]   round key for AddRoundKey
//   o_inv_shift_rows_enable  InvShiftRows active
//   o_inv_sub_bytes_enable   InvSubBytes active
//   o_add_key_enable         AddRoundKey active
//   o_inv_mix_cols_enable    InvMixColumns active (after AddRoundKey)
//   o_state_out[127:0]       working state driven into the datapath
//   o_busy                   high in every state except IDLE
//   o_done                   one-cycle plaintext-valid pulse
//   o_key_error              one-cycle key_ready timeout pulse
//   o_plain_out[127:0]       last recovered plaintext

module decryption_controller #(
    parameter int NUM_ROUNDS  = 10,
    parameter int KEY_TIMEOUT = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
`ifdef DECRYPT_ABORT_EN
    input  logic         i_abort,
`endif
    input  logic         i_decrypt_enable,
    input  logic [127:0] i_cipher_in,
    input  logic         i_key_ready,
    input  logic [127:0] i_round_result,
    output logic         o_key_schedule_start,
    output logic [3:0]   o_round_key_index,
    output logic         o_inv_shift_rows_enable,
    output logic         o_inv_sub_bytes_enable,
    output logic         o_add_key_enable,
    output logic         o_inv_mix_cols_enable,
    output logic [127:0] o_state_out,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_key_error,
    output logic [127:0] o_plain_out
);

    localparam int         TW        = (KEY_TIMEOUT > 1) ? $clog2(KEY_TIMEOUT) : 1;
    localparam logic [3:0] LP_ROUNDS = 4'(NUM_ROUNDS);
    localparam logic [TW-1:0] LP_TO_LAST = TW'(KEY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY_REQ,
        S_KEY_WAIT,
        S_INIT_ADD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [127:0]    r_state_reg;
    logic [127:0]    r_plain;
    logic [3:0]      r_round;
    logic [TW-1:0]   r_timeout;
    logic            w_timeout_last;
    logic            w_abort;

    // Last permitted KEY_WAIT cycle. It is decoded from state and counter
    // alone so key_error never depends combinationally on key_ready; in
    // that cycle the timeout takes precedence over a late key_ready.
    assign w_timeout_last = (r_state == S_KEY_WAIT) && (r_timeout == LP_TO_LAST);

`ifdef DECRYPT_ABORT_EN
    assign w_abort = i_abort && (r_state != S_IDLE) && (r_state != S_DONE);
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state            = r_state;
        o_key_schedule_start    = 1'b0;
        o_round_key_index       = 4'd0;
        o_inv_shift_rows_enable = 1'b0;
        o_inv_sub_bytes_enable  = 1'b0;
        o_add_key_enable        = 1'b0;
        o_inv_mix_cols_enable   = 1'b0;
        o_done                  = 1'b0;
        o_key_error             = 1'b0;
        o_busy                  = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (i_decrypt_enable) begin
                    w_next_state = S_KEY_REQ;
                end
            end
            S_KEY_REQ: begin
                o_key_schedule_start = 1'b1;
                w_next_state         = S_KEY_WAIT;
            end
            S_KEY_WAIT: begin
                if (w_timeout_last) begin
                    o_key_error  = 1'b1;
                    w_next_state = S_IDLE;
                end else if (i_key_ready) begin
                    w_next_state = S_INIT_ADD;
                end
            end
            S_INIT_ADD: begin
                o_add_key_enable  = 1'b1;
                o_round_key_index = LP_ROUNDS;
                w_next_state      = S_ROUND;
            end
            S_ROUND: begin
                o_inv_shift_rows_enable = 1'b1;
                o_inv_sub_bytes_enable  = 1'b1;
                o_add_key_enable        = 1'b1;
                o_inv_mix_cols_enable   = 1'b1;
                o_round_key_index       = r_round;
                if (r_round <= 4'd1) begin
                    w_next_state = S_FINAL;
                end
            end
            S_FINAL: begin
                o_inv_shift_rows_enable = 1'b1;
                o_inv_sub_bytes_enable  = 1'b1;
                o_add_key_enable        = 1'b1;
                w_next_state            = S_DONE;
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_reg <= '0;
            r_plain     <= '0;
            r_round     <= 4'd0;
            r_timeout   <= '0;
        end else if (w_abort) begin
            r_state_reg <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_decrypt_enable) begin
                        r_state_reg <= i_cipher_in;
                        r_round     <= LP_ROUNDS;
                    end
                end
                S_KEY_REQ: begin
                    r_timeout <= '0;
                end
                S_KEY_WAIT: begin
                    if (!i_key_ready && !w_timeout_last) begin
                        r_timeout <= r_timeout + TW'(1);
                    end
                end
                S_INIT_ADD, S_ROUND: begin
                    r_state_reg <= i_round_result;
                    if (r_round != 4'd0) begin
                        r_round <= r_round - 4'd1;
                    end
                end
                S_FINAL: begin
                    r_plain <= i_round_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_state_out = r_state_reg;
    assign o_plain_out = r_plain;

endmodule

// File: tb/tb_decryption_controller.sv
// tb/tb_decryption_controller.sv - randomized self-checking bench for decryption_controller

module tb_decryption_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         decrypt_enable;
    logic [127:0] cipher_in;
    logic         key_ready;
    logic [127:0] round_result;
    logic         ks_start;
    logic [3:0]   rk_idx;
    logic         sr_en, sb_en, ak_en, mc_en;
    logic [127:0] state_out;
    logic         busy, done, key_error;
    logic [127:0] plain_out;
`ifdef DECRYPT_ABORT_EN
    logic         abort;
`endif

    always #5 clk = ~clk;

    decryption_controller dut (
        .i_clk                   (clk),
        .i_rst                   (rst),
`ifdef DECRYPT_ABORT_EN
        .i_abort                 (abort),
`endif
        .i_decrypt_enable        (decrypt_enable),
        .i_cipher_in             (cipher_in),
        .i_key_ready             (key_ready),
        .i_round_result          (round_result),
        .o_key_schedule_start    (ks_start),
        .o_round_key_index       (rk_idx),
        .o_inv_shift_rows_enable (sr_en),
        .o_inv_sub_bytes_enable  (sb_en),
        .o_add_key_enable        (ak_en),
        .o_inv_mix_cols_enable   (mc_en),
        .o_state_out             (state_out),
        .o_busy                  (busy),
        .o_done                  (done),
        .o_key_error             (key_error),
        .o_plain_out             (plain_out)
    );

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [16];
    logic [127:0] exp_plain;
    int           n_vec = 0;
    int           n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? isbox[gb(s, i)] : sbox[gb(s, i)];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        int src;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(r+4*c) -: 8] = gb(s, r + 4*src);
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
        logic [7:0]   m [4];
        logic [7:0]   b;
        logic [127:0] o;
        o = '0;
        if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
        else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gm(m[(j - r + 4) % 4], gb(s, j + 4*c));
                o[127-8*(r+4*c) -: 8] = b;
            end
        return o;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int r = 11; r < 16; r++) rk[r] = '0;
    endtask

    // Forward cipher: the reference produces ciphertexts whose decryption is known.
    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (r != 10) s = mix_cols(s, 1'b0);
            s = s ^ rk[r];
        end
        return s;
    endfunction

    // External inverse datapath driven by the controller's enables.
    function automatic logic [127:0] inv_dp(input logic [127:0] s, input logic sr, input logic sb,
                                            input logic ak, input logic mc, input logic [3:0] idx);
        logic [127:0] t;
        t = s;
        if (sr) t = shift_rows(t, 1'b1);
        if (sb) t = sub_bytes(t, 1'b1);
        if (ak) t = t ^ rk[idx];
        if (mc) t = mix_cols(t, 1'b1);
        return t;
    endfunction

    assign round_result = inv_dp(state_out, sr_en, sb_en, ak_en, mc_en, rk_idx);

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode: 0 normal, 1 hold start high + restart, 2 reset at round 5,
    //       3 abort in KEY_WAIT, 4 abort at round 5
    task automatic run(input logic [127:0] ct, input logic [127:0] key, input int kdelay,
                       input logic [127:0] exp_pt, input int mode);
        bit seen;
        expand(key);
        @(negedge clk);
        decrypt_enable = 1'b1;
        cipher_in      = ct;
        key_ready      = 1'b0;
        @(negedge clk);
        check("key_req_start", ks_start, 1);
        check("key_req_busy", busy, 1);
        if (mode != 1) decrypt_enable = 1'b0;
        cipher_in = rnd128();
        for (int i = 1; i <= kdelay; i++) begin
            @(negedge clk);
            check("wait_start_low", ks_start, 0);
            check("wait_busy", busy, 1);
            cipher_in = rnd128();
`ifdef DECRYPT_ABORT_EN
            if (mode == 3) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_wait_busy", busy, 0);
                check("abort_wait_state", state_out, 0);
                check("abort_wait_plain", plain_out, exp_plain);
                check("abort_wait_done", done, 0);
                return;
            end
`endif
        end
        @(negedge clk);
        check("wait_k_enables", {sr_en, sb_en, ak_en, mc_en}, 4'b0000);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        check("init_idx", rk_idx, 10);
        check("init_enables", {sr_en, sb_en, ak_en, mc_en}, 4'b0010);
        for (int r = 9; r >= 1; r--) begin
            @(negedge clk);
            cipher_in = rnd128();
            check("round_idx", rk_idx, r);
            check("round_enables", {sr_en, sb_en, ak_en, mc_en}, 4'b1111);
            check("round_no_done", done, 0);
            if (mode == 2 && r == 5) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                exp_plain = '0;
                check("rst_busy", busy, 0);
                check("rst_enables", {sr_en, sb_en, ak_en, mc_en, ks_start}, 0);
                check("rst_state", state_out, 0);
                check("rst_plain", plain_out, 0);
                check("rst_done", done, 0);
                return;
            end
`ifdef DECRYPT_ABORT_EN
            if (mode == 4 && r == 5) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_round_busy", busy, 0);
                check("abort_round_enables", {sr_en, sb_en, ak_en, mc_en}, 0);
                check("abort_round_state", state_out, 0);
                check("abort_round_plain", plain_out, exp_plain);
                check("abort_round_done", done, 0);
                return;
            end
`endif
        end
        @(negedge clk);
        check("final_idx", rk_idx, 0);
        check("final_enables", {sr_en, sb_en, ak_en, mc_en}, 4'b1110);
        check("final_no_done", done, 0);
        if (mode == 1) cipher_in = ct;
        @(negedge clk);
        check("done_pulse", done, 1);
        check("plaintext", plain_out, exp_pt);
        exp_plain = exp_pt;
        @(negedge clk);
        check("idle_done_low", done, 0);
        check("idle_busy", busy, 0);
        if (mode == 1) begin
            @(negedge clk);
            check("restart_start", ks_start, 1);
            decrypt_enable = 1'b0;
            key_ready      = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                cipher_in = rnd128();
                if (done) seen = 1'b1;
            end
            key_ready = 1'b0;
            check("restart_done_seen", seen, 1);
            check("restart_plain", plain_out, exp_pt);
            @(negedge clk);
        end
    endtask

    task automatic run_timeout(input logic [127:0] ct);
        @(negedge clk);
        decrypt_enable = 1'b1;
        cipher_in      = ct;
        key_ready      = 1'b0;
        @(negedge clk);
        decrypt_enable = 1'b0;
        check("to_start", ks_start, 1);
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            check("to_key_error", key_error, (i == 64));
            check("to_busy", busy, 1);
            check("to_no_done", done, 0);
        end
        @(negedge clk);
        check("to_idle_busy", busy, 0);
        check("to_error_low", key_error, 0);
        check("to_plain_kept", plain_out, exp_plain);
        check("to_no_done_after", done, 0);
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    initial begin
        logic [7:0]   inv_b;
        logic [7:0]   s_b;
        logic [127:0] pt;
        logic [127:0] key;

        rst            = 1'b1;
        decrypt_enable = 1'b0;
        cipher_in      = '0;
        key_ready      = 1'b0;
`ifdef DECRYPT_ABORT_EN
        abort          = 1'b0;
`endif
        exp_plain      = '0;

        for (int x = 0; x < 256; x++) begin
            inv_b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv_b = 8'(y);
            s_b = inv_b ^ {inv_b[6:0], inv_b[7]} ^ {inv_b[5:0], inv_b[7:6]} ^
                  {inv_b[4:0], inv_b[7:5]} ^ {inv_b[3:0], inv_b[7:4]} ^ 8'h63;
            sbox[x]    = s_b;
            isbox[s_b] = 8'(x);
        end

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_busy", busy, 0);
            check("reset_done", done, 0);
            check("reset_plain", plain_out, 0);
            check("reset_start", ks_start, 0);
            check("reset_idx", rk_idx, 0);
            check("reset_state", state_out, 0);
        end

        run(C1_CT, C1_KEY, 2, C1_PT, 0);
        run_timeout(rnd128());
        run(C1_CT, C1_KEY, 2, C1_PT, 2);
        run(C1_CT, C1_KEY, 2, C1_PT, 0);

        pt  = rnd128();
        key = rnd128();
        expand(key);
        run(aes_enc(pt), key, 1, pt, 1);

        for (int n = 0; n < 6; n++) begin
            pt  = rnd128();
            key = rnd128();
            expand(key);
            run(aes_enc(pt), key, int'($urandom_range(0, 6)), pt, 0);
        end

`ifdef DECRYPT_ABORT_EN
        run(C1_CT, C1_KEY, 4, C1_PT, 3);
        pt  = rnd128();
        key = rnd128();
        expand(key);
        run(aes_enc(pt), key, 2, pt, 4);
        run(aes_enc(pt), key, 0, pt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
